// File: rtl/rx78_sysctl_if.sv
// rx78_sysctl_if -- CPU I/O bus, bank outputs and interrupt lines of the
// RX-78 system controller.
//   master : CPU / video side (drives bus strobes, address, data, irq sources)
//   slave  : rx78_sysctl (drives dout/dout_en, bank selects, int_n)
interface rx78_sysctl_if #(
  parameter int NUM_BANKS = 1,
  parameter int BANK_W    = 3,
  parameter int NUM_IRQ   = 1
);
  logic                          cen;
  logic [7:0]                    addr;
  logic [7:0]                    din;
  logic                          iorq_n;
  logic                          rd_n;
  logic                          wr_n;
  logic                          m1_n;
  logic [7:0]                    dout;
  logic                          dout_en;
  logic [NUM_BANKS*BANK_W-1:0]   bank;
  logic [NUM_IRQ-1:0]            irq_src;
  logic                          int_n;

  modport master (
    output cen, addr, din, iorq_n, rd_n, wr_n, m1_n, irq_src,
    input  dout, dout_en, bank, int_n
  );

  modport slave (
    input  cen, addr, din, iorq_n, rd_n, wr_n, m1_n, irq_src,
    output dout, dout_en, bank, int_n
  );
endinterface

// File: rtl/rx78_sysctl.sv
// rx78_sysctl -- Z80 I/O system controller: memory bank select registers and
// an edge-triggered, masked, IM2-vectored interrupt controller.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high
//   bus    : rx78_sysctl_if.slave (cen, addr, din, strobes, irq_src in;
//            dout/dout_en, bank, int_n out)
// Register window (offset from PORT_BASE):
//   +0 STATUS (read pending, write 1 to clear), +1 MASK, +2+i BANK[i]
module rx78_sysctl #(
  parameter int         NUM_BANKS    = 1,
  parameter int         BANK_W       = 3,
  parameter logic [7:0] PORT_BASE    = 8'hF0,
  parameter int         NUM_IRQ      = 1,
  parameter logic [7:0] IRQ_VEC_BASE = 8'hE0
) (
  input  logic         clk,
  input  logic         reset,
  rx78_sysctl_if.slave bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                          r_state;
  logic [NUM_BANKS-1:0][BANK_W-1:0] r_bank;
  logic [NUM_IRQ-1:0]              r_mask;
  logic [NUM_IRQ-1:0]              r_pend;
  logic [NUM_IRQ-1:0]              r_prev;
  logic                            r_primed;
  logic                            r_int_n;
  logic                            r_inta;     // current BUSY came from INTA
  logic                            r_ack_none;
  logic [2:0]                      r_ack_idx;

  logic [7:0]         w_off;
  logic               w_in_win;
  logic               w_io_wr;
  logic               w_io_rd;
  logic               w_inta;
  logic [NUM_IRQ-1:0] w_enab;
  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_clr;
  logic [2:0]         w_low_idx;
  logic               w_low_none;
  logic [2:0]         w_vec_idx;
  logic               w_vec_none;
  logic [7:0]         w_rd;

  // Offset wraps below PORT_BASE to a large value, so one compare bounds both ends.
  assign w_off    = bus.addr - PORT_BASE;
  assign w_in_win = (w_off < 8'(NUM_BANKS + 2));
  assign w_io_wr  = !bus.iorq_n &&  bus.m1_n && !bus.wr_n && w_in_win;
  assign w_io_rd  = !bus.iorq_n &&  bus.m1_n && !bus.rd_n && w_in_win;
  assign w_inta   = !bus.iorq_n && !bus.m1_n;
  assign w_enab   = r_pend & r_mask;

  // Levels present before the first sample after reset are not edges.
  assign w_edge   = r_primed ? (bus.irq_src & ~r_prev) : '0;

  // Lowest-numbered enabled pending source wins the acknowledge.
  always_comb begin
    w_low_idx  = '0;
    w_low_none = 1'b1;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_enab[i]) begin
        w_low_idx  = 3'(i);
        w_low_none = 1'b0;
      end
    end
  end

  // Pending clears: STATUS write-1 on the committing edge, or the acked
  // source on the INTA cycle end. Edges are OR'd in afterwards and win.
  always_comb begin
    w_clr = '0;
    if (r_state == S_IDLE && w_io_wr && w_off == 8'd0)
      w_clr = bus.din[NUM_IRQ-1:0];
    if (r_state == S_BUSY && bus.iorq_n && r_inta && !r_ack_none) begin
      for (int i = 0; i < NUM_IRQ; i++)
        if (r_ack_idx == 3'(i)) w_clr[i] = 1'b1;
    end
  end

  // During an acknowledged INTA the latched index is reported so the vector
  // stays stable even if new edges arrive mid-cycle.
  assign w_vec_idx  = (r_state == S_BUSY && r_inta) ? r_ack_idx  : w_low_idx;
  assign w_vec_none = (r_state == S_BUSY && r_inta) ? r_ack_none : w_low_none;

  always_comb begin
    w_rd = '0;
    if (w_off == 8'd0)
      w_rd[NUM_IRQ-1:0] = r_pend;
    else if (w_off == 8'd1)
      w_rd[NUM_IRQ-1:0] = r_mask;
    else begin
      for (int i = 0; i < NUM_BANKS; i++)
        if (w_off == 8'(i + 2)) w_rd[BANK_W-1:0] = r_bank[i];
    end
  end

  // OR-bus read path; held quiet during reset so a stuck strobe cannot drive.
  always_comb begin
    bus.dout    = '0;
    bus.dout_en = 1'b0;
    if (!reset) begin
      if (w_io_rd) begin
        bus.dout    = w_rd;
        bus.dout_en = 1'b1;
      end else if (w_inta) begin
        bus.dout    = w_vec_none ? IRQ_VEC_BASE
                                 : IRQ_VEC_BASE + {4'd0, w_vec_idx, 1'b0};
        bus.dout_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bank     <= '0;
      r_mask     <= '0;
      r_pend     <= '0;
      r_prev     <= '0;
      r_primed   <= 1'b0;
      r_int_n    <= 1'b1;
      r_inta     <= 1'b0;
      r_ack_none <= 1'b1;
      r_ack_idx  <= '0;
    end else if (bus.cen) begin
      r_prev   <= bus.irq_src;
      r_primed <= 1'b1;
      r_pend   <= (r_pend & ~w_clr) | w_edge;
      r_int_n  <= ~|w_enab;
      unique case (r_state)
        S_IDLE: begin
          if (w_io_wr) begin
            // Commit happens only on entry to BUSY: one write per access.
            r_state <= S_BUSY;
            r_inta  <= 1'b0;
            if (w_off == 8'd1) r_mask <= bus.din[NUM_IRQ-1:0];
            for (int i = 0; i < NUM_BANKS; i++)
              if (w_off == 8'(i + 2)) r_bank[i] <= bus.din[BANK_W-1:0];
          end else if (w_inta) begin
            r_state    <= S_BUSY;
            r_inta     <= 1'b1;
            r_ack_idx  <= w_low_idx;
            r_ack_none <= w_low_none;
          end
        end
        S_BUSY: begin
          if (bus.iorq_n) begin
            r_state <= S_IDLE;
            r_inta  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.bank  = r_bank;
  assign bus.int_n = r_int_n;

endmodule
